// File: rtl/gbt_link_sequencer.sv
// ============================================================================
//  Module      : gbt_link_sequencer
//  Description : Bring-up and recovery sequencer for the GBT transceiver link.
//                Drives the GBT core reset and bitslip release, qualifies
//                link_ready as stable, retries on lock timeout, latches a fault
//                after repeated failures, restarts on SFP LOS or link drop.
//                Optional macro GBT_SEQ_UPTIME_EN enables the S_UP uptime
//                counter on uptime_o (tied to 0 when undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef GBT_CKRS_T_DEFINED
`define GBT_CKRS_T_DEFINED
typedef struct packed {
    logic clk;
    logic reset;
} ckrs_t;
`endif

module gbt_link_sequencer #(
    parameter int RESET_CYCLES  = 40,
    parameter int LOCK_TIMEOUT  = 4000000,
    parameter int STABLE_CYCLES = 4000,
    parameter int MAX_RETRIES   = 8
) (
    input  ckrs_t       ClkRs_ix,
    input  logic        sfp_los_i,
    input  logic        link_ready_i,
    input  logic        force_reset_i,
    input  logic        fault_clear_i,
    output logic        gbt_reset_o,
    output logic        bitslip_reset_o,
    output logic        link_up_o,
    output logic        fault_o,
    output logic [2:0]  state_o,
    output logic [3:0]  retry_cnt_o,
    output logic [15:0] loss_cnt_o,
    output logic [31:0] uptime_o
);

    // One timer serves all timed states; it only has to reach the largest
    // terminal count minus one, since each timed state leaves at that count.
    localparam int c_timer_max =
        (LOCK_TIMEOUT >= RESET_CYCLES && LOCK_TIMEOUT >= STABLE_CYCLES) ? LOCK_TIMEOUT :
        (RESET_CYCLES >= STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES;
    localparam int c_timer_w = (c_timer_max > 1) ? $clog2(c_timer_max) : 1;

    localparam logic [c_timer_w-1:0] c_reset_last  = c_timer_w'(RESET_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_lock_last   = c_timer_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_timer_w-1:0] c_stable_last = c_timer_w'(STABLE_CYCLES - 1);
    localparam logic [3:0]           c_max_retries = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_LOS       = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_UP        = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    logic clk;
    logic rst;
    assign clk = ClkRs_ix.clk;
    assign rst = ClkRs_ix.reset;

    state_t                 r_state;
    logic [c_timer_w-1:0]   r_timer;
    logic [3:0]             r_retry;
    logic [15:0]            r_loss_cnt;

    state_t                 w_next;
    logic                   w_restart;
    logic [3:0]             w_retry_next;
    logic [3:0]             w_retry_inc;
    logic                   w_loss_inc;
    logic [15:0]            w_loss_next;
    logic                   w_timed;

    assign w_retry_inc = r_retry + 4'd1;

    // Next-state and counter-update decisions in priority order:
    // LOS, forced restart, fault clear, then the per-state rules.
    always_comb begin
        w_next       = r_state;
        w_restart    = 1'b0;
        w_retry_next = r_retry;
        w_loss_inc   = 1'b0;
        if (sfp_los_i) begin
            w_next       = S_LOS;
            w_retry_next = 4'd0;
            w_loss_inc   = (r_state == S_UP);
        end else if (force_reset_i && (r_state != S_LOS)) begin
            w_next    = S_RESET;
            w_restart = 1'b1;
        end else if (fault_clear_i && (r_state == S_FAULT)) begin
            w_next       = S_RESET;
            w_retry_next = 4'd0;
        end else begin
            case (r_state)
                S_LOS: w_next = S_RESET;
                S_RESET: begin
                    if (r_timer == c_reset_last) w_next = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (link_ready_i) begin
                        w_next = S_STABLE;
                    end else if (r_timer == c_lock_last) begin
                        w_retry_next = w_retry_inc;
                        w_next       = (w_retry_inc == c_max_retries) ? S_FAULT : S_RESET;
                    end
                end
                S_STABLE: begin
                    if (!link_ready_i) begin
                        w_next = S_WAIT_LOCK;
                    end else if (r_timer == c_stable_last) begin
                        w_next       = S_UP;
                        w_retry_next = 4'd0;
                    end
                end
                S_UP: begin
                    if (!link_ready_i) begin
                        w_next     = S_RESET;
                        w_loss_inc = 1'b1;
                    end
                end
                S_FAULT: w_next = S_FAULT;
                default: w_next = S_RESET;
            endcase
        end
    end

    // Saturating link-loss counter update.
    always_comb begin
        w_loss_next = r_loss_cnt;
        if (w_loss_inc && (r_loss_cnt != 16'hFFFF)) w_loss_next = r_loss_cnt + 16'd1;
    end

    assign w_timed = (w_next == S_RESET) || (w_next == S_WAIT_LOCK) || (w_next == S_STABLE);

    // State, shared timer and counters; outputs are decoded from the next
    // state so they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_RESET;
            r_timer         <= '0;
            r_retry         <= 4'd0;
            r_loss_cnt      <= 16'd0;
            gbt_reset_o     <= 1'b1;
            bitslip_reset_o <= 1'b0;
            link_up_o       <= 1'b0;
            fault_o         <= 1'b0;
            state_o         <= S_RESET;
        end else begin
            r_state    <= w_next;
            r_retry    <= w_retry_next;
            r_loss_cnt <= w_loss_next;
            if ((w_next != r_state) || w_restart || !w_timed) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_timer_w'(1);
            end
            gbt_reset_o     <= (w_next == S_LOS) || (w_next == S_RESET) || (w_next == S_FAULT);
            bitslip_reset_o <= (w_next == S_UP);
            link_up_o       <= (w_next == S_UP);
            fault_o         <= (w_next == S_FAULT);
            state_o         <= w_next;
        end
    end

    assign retry_cnt_o = r_retry;
    assign loss_cnt_o  = r_loss_cnt;

`ifdef GBT_SEQ_UPTIME_EN
    logic [31:0] r_uptime;

    // Cycles spent in S_UP: zeroed on entry, saturating, held after exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_uptime <= 32'd0;
        end else if ((w_next == S_UP) && (r_state != S_UP)) begin
            r_uptime <= 32'd0;
        end else if ((r_state == S_UP) && (r_uptime != 32'hFFFF_FFFF)) begin
            r_uptime <= r_uptime + 32'd1;
        end
    end

    assign uptime_o = r_uptime;
`else
    assign uptime_o = 32'd0;
`endif

endmodule

`default_nettype wire
